alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Parametrised successor to the single-cycle ALU source select. It builds both ALU operands and the store-data value for the pipelined CPU:
- register-file or forwarded values from EX/MEM and MEM/WB;
- an extended immediate on operand 2 when `alu_src`=1.

Results are captured into a one-entry ID/EX pipeline register with valid/ready handshake and flush. It sits between decode/register-read and the execute stage.

## Interface
- `WIDTH`, 16, datapath width.
- `IMM_WIDTH`, 8, raw immediate width (1 ≤ `IMM_WIDTH` ≤ `WIDTH`).
- `REG_ADDR_W`, 2, register address width.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `in_valid` in 1 — decode presents an operand set.
- `in_ready` out 1 — stage can accept this cycle.
- `rs1_addr`, `rs2_addr` in `REG_ADDR_W` — source register numbers.
- `read_data_1`, `read_data_2` in `WIDTH` — register-file read data.
- `immediate` in `IMM_WIDTH` — raw immediate field.
- `imm_mode` in 2 — 00 sign-extend, 01 zero-extend, 10 upper (imm << (`WIDTH`-`IMM_WIDTH`)), 11 treated as 00.
- `alu_src` in 1 — 1 selects the immediate for operand 2.
- `flush` in 1 — kill held and incoming entries.
- `exmem_wr_en` in 1, `exmem_rd_addr` in `REG_ADDR_W`, `exmem_result` in `WIDTH` — EX/MEM forward source.
- `memwb_wr_en` in 1, `memwb_rd_addr` in `REG_ADDR_W`, `memwb_result` in `WIDTH` — MEM/WB forward source.
- `out_valid` out 1 — registered operand set valid.
- `out_ready` in 1 — execute consumes this cycle.
- `alu_input_1`, `alu_input_2` out `WIDTH` — registered ALU operands.
- `store_data` out `WIDTH` — registered forwarded rs2 value, independent of `alu_src`.

## Operation
- Per operand, the forward select is:
  - EX/MEM when `exmem_wr_en` && `exmem_rd_addr`==rsN;
  - else MEM/WB when `memwb_wr_en` && `memwb_rd_addr`==rsN;
  - else register file.
- No hardwired zero register; address 0 forwards like any other.
- `alu_input_2` = extended immediate if `alu_src`, else forwarded rs2.
- `store_data` = forwarded rs2 always.
- Accept = `in_valid` && `in_ready`.
- `in_ready` = !`out_valid` || `out_ready` || `flush` (combinational).
- On accept without flush, all three data outputs load and `out_valid`<=1.
- If `out_valid` && `out_ready` and there is no accept, `out_valid`<=0. Data registers keep their last value.
- Operands are sampled only at accept. While held (`out_valid` && !`out_ready`), outputs stay bit-stable and forwarding inputs are ignored. Upstream hazard logic guarantees correctness.
- `flush` has priority:
  - next edge `out_valid`<=0;
  - a concurrent input beat is consumed (`in_ready`=1) and discarded;
  - data registers are not updated.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 beat/cycle when `out_ready`=1.
- Reset (async assert, released synchronously by the system): `out_valid`=0; `alu_input_1`, `alu_input_2`, `store_data`=0; hence `in_ready`=1.
- Reset mid-hold drops the entry immediately. No output glitch to a stale valid.
- Simultaneous consume and accept: new entry loads and `out_valid` stays 1 (back-to-back).
- `IMM_WIDTH`==`WIDTH`: all modes pass the immediate unchanged, and the upper shift is 0.

## Configuration
- `ALU_OPERAND_FWD_EN` defined: forwarding as above.
- `ALU_OPERAND_FWD_EN` undefined: forward ports remain present but are ignored. Operands come from `read_data_1` and `read_data_2` only. Handshake, flush and immediate logic are unchanged.

## Structure
- Package `alu_operand_pkg`:
  - `imm_mode` codes `IMM_SEXT`, `IMM_ZEXT`, `IMM_UPPER`;
  - forward-select enum `FWD_RF`/`FWD_EXMEM`/`FWD_MEMWB`.
- Sub-module `operand_fwd_unit`: per-operand priority compare/mux, instantiated twice (rs1, rs2).
- Immediate extender and pipeline register live in the top.

## Test plan
- `immediate`=8'hF0, `alu_src`=1: `imm_mode`=00 -> `alu_input_2`=16'hFFF0; 01 -> 16'h00F0; 10 -> 16'hF000; each one cycle after accept.
- rs2=2, `read_data_2`=16'h0BAD, EX/MEM rd=2 value 16'h1234, MEM/WB rd=2 value 16'h5678, `alu_src`=0:
  - result 16'h1234;
  - with `exmem_wr_en`=0 -> 16'h5678;
  - with macro undefined -> 16'h0BAD.
- `alu_src`=1 with EX/MEM forwarding rs2=16'h1234: `alu_input_2`=immediate and `store_data`=16'h1234.
- Accept beat A, then hold `out_ready`=0 for 3 cycles while presenting B:
  - `in_ready`=0 and outputs stable at A;
  - when `out_ready`=1, B is accepted that cycle and appears next cycle with `out_valid`=1.
- `flush`=1 while A is held and B is presented: `in_ready`=1, next cycle `out_valid`=0, outputs still A.
- Assert `reset_n`=0 mid-hold: `out_valid`=0 and all data outputs 0 without waiting for `clk`.

Source files
------------

// File: rtl/alu_operand_pkg.sv
// Shared codes for the ALU operand stage: immediate-extension modes and forward-select values.
package alu_operand_pkg;

    localparam logic [1:0] IMM_SEXT  = 2'b00;
    localparam logic [1:0] IMM_ZEXT  = 2'b01;
    localparam logic [1:0] IMM_UPPER = 2'b10;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/operand_fwd_unit.sv
// Priority forward mux for one source operand: EX/MEM over MEM/WB over register file.
// Compare logic exists only when ALU_OPERAND_FWD_EN is defined; otherwise the register value passes through.
module operand_fwd_unit import alu_operand_pkg::*; #(
    parameter int WIDTH      = 16,
    parameter int REG_ADDR_W = 2
) (
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [WIDTH-1:0]      rf_data,
    input  logic                  exmem_wr_en,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
    input  logic [WIDTH-1:0]      exmem_result,
    input  logic                  memwb_wr_en,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
    input  logic [WIDTH-1:0]      memwb_result,
    output logic [WIDTH-1:0]      fwd_data
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_RF;
`ifdef ALU_OPERAND_FWD_EN
        // Address 0 is an ordinary register here, so no zero-register exclusion.
        if (exmem_wr_en && (exmem_rd_addr == rs_addr))
            sel = FWD_EXMEM;
        else if (memwb_wr_en && (memwb_rd_addr == rs_addr))
            sel = FWD_MEMWB;
`endif
    end

`ifndef ALU_OPERAND_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{rs_addr, exmem_wr_en, exmem_rd_addr, exmem_result,
                          memwb_wr_en, memwb_rd_addr, memwb_result};
`endif

    always_comb begin
        case (sel)
            FWD_EXMEM: fwd_data = exmem_result;
            FWD_MEMWB: fwd_data = memwb_result;
            default:   fwd_data = rf_data;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand build (forwarding + immediate extension) feeding a one-entry ID/EX register with valid/ready and flush.
// Optional macro: ALU_OPERAND_FWD_EN enables EX/MEM and MEM/WB forwarding.
module alu_operand_stage import alu_operand_pkg::*; #(
    parameter int WIDTH      = 16,
    parameter int IMM_WIDTH  = 8,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [WIDTH-1:0]      read_data_1,
    input  logic [WIDTH-1:0]      read_data_2,
    input  logic [IMM_WIDTH-1:0]  immediate,
    input  logic [1:0]            imm_mode,
    input  logic                  alu_src,
    input  logic                  flush,
    input  logic                  exmem_wr_en,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
    input  logic [WIDTH-1:0]      exmem_result,
    input  logic                  memwb_wr_en,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
    input  logic [WIDTH-1:0]      memwb_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      alu_input_1,
    output logic [WIDTH-1:0]      alu_input_2,
    output logic [WIDTH-1:0]      store_data
);

    // With IMM_WIDTH == WIDTH the upper shift is zero and every mode returns the raw field.
    function automatic logic [WIDTH-1:0] ext_imm(input logic [IMM_WIDTH-1:0] imm,
                                                 input logic [1:0]           mode);
        logic signed [IMM_WIDTH-1:0] imm_s;
        logic signed [WIDTH-1:0]     sext;
        logic        [WIDTH-1:0]     zext;
        imm_s = $signed(imm);
        sext  = WIDTH'(imm_s);
        zext  = WIDTH'(imm);
        case (mode)
            IMM_ZEXT:  ext_imm = zext;
            IMM_UPPER: ext_imm = zext << (WIDTH - IMM_WIDTH);
            default:   ext_imm = sext;
        endcase
    endfunction

    // ---- stage p0: operand select (combinational) ----
    logic [WIDTH-1:0] rs1_fwd_p0;
    logic [WIDTH-1:0] rs2_fwd_p0;
    logic [WIDTH-1:0] op2_p0;
    logic             accept_p0;

    operand_fwd_unit #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .rs_addr       (rs1_addr),
        .rf_data       (read_data_1),
        .exmem_wr_en   (exmem_wr_en),
        .exmem_rd_addr (exmem_rd_addr),
        .exmem_result  (exmem_result),
        .memwb_wr_en   (memwb_wr_en),
        .memwb_rd_addr (memwb_rd_addr),
        .memwb_result  (memwb_result),
        .fwd_data      (rs1_fwd_p0)
    );

    operand_fwd_unit #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .rs_addr       (rs2_addr),
        .rf_data       (read_data_2),
        .exmem_wr_en   (exmem_wr_en),
        .exmem_rd_addr (exmem_rd_addr),
        .exmem_result  (exmem_result),
        .memwb_wr_en   (memwb_wr_en),
        .memwb_rd_addr (memwb_rd_addr),
        .memwb_result  (memwb_result),
        .fwd_data      (rs2_fwd_p0)
    );

    assign op2_p0    = alu_src ? ext_imm(immediate, imm_mode) : rs2_fwd_p0;
    assign in_ready  = !out_valid || out_ready || flush;
    assign accept_p0 = in_valid && in_ready;

    // ---- stage p1: ID/EX register ----
    logic             vld_p1;
    logic [WIDTH-1:0] op1_p1;
    logic [WIDTH-1:0] op2_p1;
    logic [WIDTH-1:0] store_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1   <= 1'b0;
            op1_p1   <= '0;
            op2_p1   <= '0;
            store_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1   <= 1'b1;
            op1_p1   <= rs1_fwd_p0;
            op2_p1   <= op2_p0;
            store_p1 <= rs2_fwd_p0;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid   = vld_p1;
    assign alu_input_1 = op1_p1;
    assign alu_input_2 = op2_p1;
    assign store_data  = store_p1;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: vector table for operand building plus hold/flush/reset sequences.
module tb_alu_operand_stage;

`ifdef ALU_OPERAND_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [1:0]  rs1_addr, rs2_addr, imm_mode;
    logic [15:0] read_data_1, read_data_2;
    logic [7:0]  immediate;
    logic        alu_src;
    logic        exmem_wr_en, memwb_wr_en;
    logic [1:0]  exmem_rd_addr, memwb_rd_addr;
    logic [15:0] exmem_result, memwb_result;
    logic [15:0] alu_input_1, alu_input_2, store_data;

    logic [15:0] imm16;
    logic        w_in_ready, w_out_valid;
    logic [15:0] w_a1, w_a2, w_sd;

    always #5 clk = ~clk;

    alu_operand_stage #(.WIDTH(16), .IMM_WIDTH(8), .REG_ADDR_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .immediate(immediate), .imm_mode(imm_mode), .alu_src(alu_src), .flush(flush),
        .exmem_wr_en(exmem_wr_en), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
        .memwb_wr_en(memwb_wr_en), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_input_1(alu_input_1), .alu_input_2(alu_input_2), .store_data(store_data)
    );

    alu_operand_stage #(.WIDTH(16), .IMM_WIDTH(16), .REG_ADDR_W(2)) dut_wide (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .immediate(imm16), .imm_mode(imm_mode), .alu_src(alu_src), .flush(flush),
        .exmem_wr_en(exmem_wr_en), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
        .memwb_wr_en(memwb_wr_en), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .alu_input_1(w_a1), .alu_input_2(w_a2), .store_data(w_sd)
    );

    typedef struct {
        logic [1:0]  rs1, rs2;
        logic [15:0] rd1, rd2;
        logic [7:0]  imm;
        logic [1:0]  mode;
        logic        src;
        logic        ex_en;
        logic [1:0]  ex_rd;
        logic [15:0] ex_res;
        logic        wb_en;
        logic [1:0]  wb_rd;
        logic [15:0] wb_res;
        logic [15:0] e1, e2, esd;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rs1_addr      = v.rs1;
        rs2_addr      = v.rs2;
        read_data_1   = v.rd1;
        read_data_2   = v.rd2;
        immediate     = v.imm;
        imm_mode      = v.mode;
        alu_src       = v.src;
        exmem_wr_en   = v.ex_en;
        exmem_rd_addr = v.ex_rd;
        exmem_result  = v.ex_res;
        memwb_wr_en   = v.wb_en;
        memwb_rd_addr = v.wb_rd;
        memwb_result  = v.wb_res;
    endtask

    vec_t va, vb;

    initial begin
        //            rs1   rs2   rd1       rd2       imm    mode  src  exen exrd  exres     wben wbrd  wbres     e1  e2  esd
        vecs[0]  = '{2'd1, 2'd3, 16'h1111, 16'h2222, 8'hF0, 2'b00, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000,
                     16'h1111, 16'hFFF0, 16'h2222};
        vecs[1]  = '{2'd1, 2'd3, 16'h1111, 16'h2222, 8'hF0, 2'b01, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000,
                     16'h1111, 16'h00F0, 16'h2222};
        vecs[2]  = '{2'd1, 2'd3, 16'h1111, 16'h2222, 8'hF0, 2'b10, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000,
                     16'h1111, 16'hF000, 16'h2222};
        vecs[3]  = '{2'd1, 2'd3, 16'h1111, 16'h2222, 8'hF0, 2'b11, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000,
                     16'h1111, 16'hFFF0, 16'h2222};
        vecs[4]  = '{2'd2, 2'd1, 16'h3333, 16'h4444, 8'h7F, 2'b00, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000,
                     16'h3333, 16'h007F, 16'h4444};
        vecs[5]  = '{2'd0, 2'd2, 16'h0001, 16'h0BAD, 8'h00, 2'b00, 1'b0, 1'b1, 2'd2, 16'h1234, 1'b1, 2'd2, 16'h5678,
                     16'h0001, FWD ? 16'h1234 : 16'h0BAD, FWD ? 16'h1234 : 16'h0BAD};
        vecs[6]  = '{2'd0, 2'd2, 16'h0001, 16'h0BAD, 8'h00, 2'b00, 1'b0, 1'b0, 2'd2, 16'h1234, 1'b1, 2'd2, 16'h5678,
                     16'h0001, FWD ? 16'h5678 : 16'h0BAD, FWD ? 16'h5678 : 16'h0BAD};
        vecs[7]  = '{2'd0, 2'd2, 16'h0001, 16'h0BAD, 8'hF0, 2'b01, 1'b1, 1'b1, 2'd2, 16'h1234, 1'b0, 2'd0, 16'h0000,
                     16'h0001, 16'h00F0, FWD ? 16'h1234 : 16'h0BAD};
        vecs[8]  = '{2'd0, 2'd1, 16'h0001, 16'h0002, 8'h00, 2'b00, 1'b0, 1'b1, 2'd0, 16'hABCD, 1'b1, 2'd1, 16'h5678,
                     FWD ? 16'hABCD : 16'h0001, FWD ? 16'h5678 : 16'h0002, FWD ? 16'h5678 : 16'h0002};
        vecs[9]  = '{2'd3, 2'd3, 16'h0003, 16'h0004, 8'h00, 2'b00, 1'b0, 1'b1, 2'd3, 16'hCAFE, 1'b1, 2'd3, 16'hBEEF,
                     FWD ? 16'hCAFE : 16'h0003, FWD ? 16'hCAFE : 16'h0004, FWD ? 16'hCAFE : 16'h0004};
        vecs[10] = '{2'd1, 2'd0, 16'h5555, 16'h6666, 8'h80, 2'b10, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000,
                     16'h5555, 16'h8000, 16'h6666};

        va = vecs[0];
        va.rs1 = 2'd1; va.rs2 = 2'd2; va.rd1 = 16'hAAAA; va.rd2 = 16'hA2A2; va.src = 1'b0;
        vb = va;
        vb.rd1 = 16'hBBBB; vb.rd2 = 16'hB2B2;

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; imm16 = 16'h0;
        drive(vecs[0]);
        #1;
        chk("reset_out_valid", 16'(out_valid), 16'h0);
        chk("reset_in_ready", 16'(in_ready), 16'h1);
        chk("reset_a1", alu_input_1, 16'h0);
        chk("reset_a2", alu_input_2, 16'h0);
        chk("reset_sd", store_data, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table: one accept per cycle, so consecutive vectors also exercise back-to-back loading.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 16'(out_valid), 16'h1);
            chk($sformatf("vec%0d_a1", i), alu_input_1, vecs[i].e1);
            chk($sformatf("vec%0d_a2", i), alu_input_2, vecs[i].e2);
            chk($sformatf("vec%0d_sd", i), store_data, vecs[i].esd);
        end

        // Full-width immediate: every mode passes the field through.
        for (int m = 0; m < 3; m++) begin
            imm16 = 16'h8001;
            imm_mode = 2'(m);
            alu_src = 1'b1;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("wide_mode%0d_a2", m), w_a2, 16'h8001);
        end

        // Accept A, then hold 3 cycles with B presented.
        drive(va);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("holdA_a1", alu_input_1, 16'hAAAA);
        drive(vb);
        exmem_wr_en = 1'b1; exmem_rd_addr = 2'd1; exmem_result = 16'hDEAD;
        out_ready = 1'b0;
        #1;
        chk("hold_in_ready", 16'(in_ready), 16'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("hold%0d_valid", c), 16'(out_valid), 16'h1);
            chk($sformatf("hold%0d_a1", c), alu_input_1, 16'hAAAA);
            chk($sformatf("hold%0d_sd", c), store_data, 16'hA2A2);
            chk($sformatf("hold%0d_in_ready", c), 16'(in_ready), 16'h0);
        end
        drive(vb);
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 16'(in_ready), 16'h1);
        @(posedge clk);
        @(negedge clk);
        chk("B_valid", 16'(out_valid), 16'h1);
        chk("B_a1", alu_input_1, 16'hBBBB);
        chk("B_sd", store_data, 16'hB2B2);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("drain_valid", 16'(out_valid), 16'h0);
        chk("drain_a1_kept", alu_input_1, 16'hBBBB);

        // Flush while A is held and B is presented.
        drive(va);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(vb);
        out_ready = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 16'(in_ready), 16'h1);
        @(posedge clk);
        @(negedge clk);
        chk("flush_valid", 16'(out_valid), 16'h0);
        chk("flush_a1_kept", alu_input_1, 16'hAAAA);
        chk("flush_sd_kept", store_data, 16'hA2A2);
        flush = 1'b0;
        in_valid = 1'b0;

        // Asynchronous reset while holding an entry.
        drive(va);
        va.rd1 = 16'h7777;
        drive(va);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("prerst_a1", alu_input_1, 16'h7777);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 16'(out_valid), 16'h0);
        chk("midrst_a1", alu_input_1, 16'h0);
        chk("midrst_a2", alu_input_2, 16'h0);
        chk("midrst_sd", store_data, 16'h0);
        chk("midrst_in_ready", 16'(in_ready), 16'h1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("postrst_valid", 16'(out_valid), 16'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
